// File: rtl/axis_frame_gen.sv
// Cuts an unframed AXI-Stream sample stream into FRAME_LEN-beat packets (tuser on first beat, tlast on last)
// behind a two-entry skid buffer so that s_tready is a flop and never depends on m_tready.
module axis_frame_gen #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 4096,
    parameter int CW        = 12,
    parameter int FCW       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [DW-1:0]  s_tdata,
    input  logic           s_tvalid,
    output logic           s_tready,
    output logic [DW-1:0]  m_tdata,
    output logic           m_tvalid,
    output logic           m_tlast,
    output logic           m_tuser,
    input  logic           m_tready,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_beat_idx;
    logic [FCW-1:0]  r_frame_cnt;
    logic            r_s_tready;
    logic            r_busy;
    logic [DW-1:0]   r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic            r_m_user;
    logic [DW-1:0]   r_sk_data;
    logic            r_sk_valid;
    logic            r_sk_last;
    logic            r_sk_user;

    logic            w_accept;
    logic            w_last;
    logic            w_sof;
    logic            w_out_free;
    state_t          w_state_nx;
    logic [DW-1:0]   w_m_data_nx;
    logic            w_m_valid_nx;
    logic            w_m_last_nx;
    logic            w_m_user_nx;
    logic [DW-1:0]   w_sk_data_nx;
    logic            w_sk_valid_nx;
    logic            w_sk_last_nx;
    logic            w_sk_user_nx;

    always_comb begin
        w_accept   = s_tvalid & r_s_tready;
        w_last     = (r_beat_idx == LAST_IDX);
        w_sof      = (r_beat_idx == '0);
        w_out_free = ~r_m_valid | m_tready;

        w_m_data_nx   = r_m_data;
        w_m_valid_nx  = r_m_valid;
        w_m_last_nx   = r_m_last;
        w_m_user_nx   = r_m_user;
        w_sk_data_nx  = r_sk_data;
        w_sk_valid_nx = r_sk_valid;
        w_sk_last_nx  = r_sk_last;
        w_sk_user_nx  = r_sk_user;

        // s_tready is low whenever the skid entry is full, so accept and skid_valid never coincide
        if (w_out_free) begin
            if (r_sk_valid) begin
                w_m_data_nx   = r_sk_data;
                w_m_valid_nx  = 1'b1;
                w_m_last_nx   = r_sk_last;
                w_m_user_nx   = r_sk_user;
                w_sk_valid_nx = 1'b0;
            end else if (w_accept) begin
                w_m_data_nx  = s_tdata;
                w_m_valid_nx = 1'b1;
                w_m_last_nx  = w_last;
                w_m_user_nx  = w_sof;
            end else begin
                w_m_valid_nx = 1'b0;
            end
        end else if (w_accept) begin
            w_sk_data_nx  = s_tdata;
            w_sk_valid_nx = 1'b1;
            w_sk_last_nx  = w_last;
            w_sk_user_nx  = w_sof;
        end

        w_state_nx = r_state;
        case (r_state)
            IDLE: if (enable) w_state_nx = RUN;
            RUN: begin
                // Leave only on a frame boundary: either closing the frame now or none started yet
                if (!enable && w_accept && w_last)
                    w_state_nx = IDLE;
                else if (!enable && !w_accept && w_sof)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_beat_idx  <= '0;
            r_frame_cnt <= '0;
            r_s_tready  <= 1'b0;
            r_busy      <= 1'b0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_user    <= 1'b0;
            r_sk_data   <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_last   <= 1'b0;
            r_sk_user   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_s_tready <= (w_state_nx == RUN) & ~w_sk_valid_nx;
            r_busy     <= (w_state_nx != IDLE) | w_m_valid_nx | w_sk_valid_nx;
            if (w_accept) begin
                r_beat_idx <= w_last ? '0 : r_beat_idx + CW'(1);
                if (w_last)
                    r_frame_cnt <= r_frame_cnt + FCW'(1);
            end
            r_m_data   <= w_m_data_nx;
            r_m_valid  <= w_m_valid_nx;
            r_m_last   <= w_m_last_nx;
            r_m_user   <= w_m_user_nx;
            r_sk_data  <= w_sk_data_nx;
            r_sk_valid <= w_sk_valid_nx;
            r_sk_last  <= w_sk_last_nx;
            r_sk_user  <= w_sk_user_nx;
        end
    end

    assign s_tready  = r_s_tready;
    assign m_tdata   = r_m_data;
    assign m_tvalid  = r_m_valid;
    assign m_tlast   = r_m_last;
    assign m_tuser   = r_m_user;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule
